// File: rtl/ram_top_if.sv
// Bus bundle for ram_top: RAM port, two register read ports, one register write port
// and the write-data source select. The bench drives through master; ram_top takes slave.
interface ram_top_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    // No valid/ready handshake here: enables are sampled on every rising edge and
    // read data is purely combinational from the current addresses.
    logic [1:0]            choice;
    logic                  ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [4:0]            raddr1;
    logic [4:0]            raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  we;
    logic [4:0]            waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output choice, ram_wen, ram_addr, ram_wdata,
        output raddr1, raddr2, we, waddr, wdata,
        input  ram_rdata, rdata1, rdata2
    );

    modport slave (
        input  choice, ram_wen, ram_addr, ram_wdata,
        input  raddr1, raddr2, we, waddr, wdata,
        output ram_rdata, rdata1, rdata2
    );
endinterface

// File: rtl/ram_top.sv
// Data RAM plus 32x32 register file with a choice-controlled cross path so a word
// can move RAM->register or register->RAM in a single clock.
module ram_top #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ram_top_if.slave     bus
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int REG_COUNT = 32;

    logic [DATA_WIDTH-1:0] mem  [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [DATA_WIDTH-1:0] ram_rdata_int;
    logic [DATA_WIDTH-1:0] rdata1_int;
    logic [DATA_WIDTH-1:0] rdata2_int;
    logic [DATA_WIDTH-1:0] ram_wsel;
    logic [DATA_WIDTH-1:0] reg_wsel;

    // Register 0 is forced to zero on read so it is correct even before the first reset.
    always_comb begin
        ram_rdata_int = mem[bus.ram_addr];
        rdata1_int    = (bus.raddr1 == 5'd0) ? '0 : regs[bus.raddr1];
        rdata2_int    = (bus.raddr2 == 5'd0) ? '0 : regs[bus.raddr2];
    end

    assign bus.ram_rdata = ram_rdata_int;
    assign bus.rdata1    = rdata1_int;
    assign bus.rdata2    = rdata2_int;

    // Cross paths take the pre-edge read values, so same-edge transfers see old data.
    always_comb begin
        ram_wsel = bus.ram_wdata;
        reg_wsel = bus.wdata;
        case (bus.choice)
            2'b01: reg_wsel = ram_rdata_int;
            2'b00: ram_wsel = rdata1_int;
            2'b10: begin
                reg_wsel = ram_rdata_int;
                ram_wsel = rdata1_int;
            end
            default: begin
                ram_wsel = bus.ram_wdata;
                reg_wsel = bus.wdata;
            end
        endcase
    end

    // RAM contents survive reset; only the write is suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && bus.ram_wen) begin
            mem[bus.ram_addr] <= ram_wsel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != 5'd0)) begin
            regs[bus.waddr] <= reg_wsel;
        end
    end
endmodule

// File: tb/tb_ram_top.sv
// Directed plus randomized checks of ram_top against an array/associative-array
// reference model of the RAM, register file and choice-controlled cross paths.
module tb_ram_top;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_top_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    ram_top #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: known RAM words only, and all 32 registers.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_reg [32];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ram_read(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'hxxxx_xxxx;
    endfunction

    // Model one rising edge from the inputs currently applied.
    task automatic model_edge();
        logic [31:0] old_ram;
        logic [31:0] old_rd1;
        logic        reg_from_ram;
        logic        ram_from_reg;
        old_ram      = ref_ram_read(int'(bus.ram_addr));
        old_rd1      = ref_reg[bus.raddr1];
        reg_from_ram = (bus.choice == 2'b01) || (bus.choice == 2'b10);
        ram_from_reg = (bus.choice == 2'b00) || (bus.choice == 2'b10);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
        end else begin
            if (bus.ram_wen) ref_mem[int'(bus.ram_addr)] = ram_from_reg ? old_rd1 : bus.ram_wdata;
            if (bus.we && bus.waddr != 5'd0) ref_reg[bus.waddr] = reg_from_ram ? old_ram : bus.wdata;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.choice    = 2'b11;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.we        = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
    endtask

    initial begin
        logic [31:0] rnd;
        for (int i = 0; i < 32; i++) ref_reg[i] = 32'hxxxx_xxxx;

        // Reset
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd31;
        #1;
        check("reset_rdata1", bus.rdata1, 32'd0);
        check("reset_rdata2", bus.rdata2, 32'd0);

        // RAM write/read, independent mode
        bus.choice  = 2'b11;
        bus.ram_wen = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            bus.ram_addr  = 16'(k);
            bus.ram_wdata = 32'(k);
            tick();
        end
        bus.ram_wen = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            bus.ram_addr = 16'(k);
            #1;
            check("ram_wr_rd", bus.ram_rdata, 32'(k));
        end

        // RAM -> reg
        bus.choice = 2'b01;
        bus.we     = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            bus.ram_addr = 16'(k);
            bus.waddr    = 5'(k);
            bus.wdata    = $urandom;
            tick();
        end
        bus.we = 1'b0;
        for (int k = 0; k <= 31; k++) begin
            bus.raddr1 = 5'(k);
            #1;
            check("ram_to_reg", bus.rdata1, ref_reg[k]);
        end
        bus.raddr1 = 5'd0;
        #1;
        check("reg0_reads_zero", bus.rdata1, 32'd0);

        // Reg overwrite, plus ignored write to register 0
        bus.choice = 2'b11;
        bus.we     = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            bus.waddr = 5'(k);
            bus.wdata = 32'(2 * (k - 1));
            tick();
        end
        bus.waddr = 5'd0;
        bus.wdata = 32'h1234_5678;
        tick();
        bus.we     = 1'b0;
        bus.raddr2 = 5'd5;
        #1;
        check("reg_overwrite_r5", bus.rdata2, 32'd8);
        bus.raddr2 = 5'd0;
        #1;
        check("reg0_write_ignored", bus.rdata2, 32'd0);

        // Reg -> RAM
        bus.choice  = 2'b00;
        bus.ram_wen = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            bus.ram_addr  = 16'(k);
            bus.raddr1    = 5'(k);
            bus.ram_wdata = $urandom;
            tick();
        end
        bus.choice  = 2'b11;
        bus.ram_wen = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            bus.ram_addr = 16'(k);
            #1;
            check("reg_to_ram", bus.ram_rdata, 32'(2 * (k - 1)));
        end

        // Same-edge hazard: RAM takes the old reg[3] while reg[3] is rewritten
        bus.choice    = 2'b00;
        bus.raddr1    = 5'd3;
        bus.we        = 1'b1;
        bus.waddr     = 5'd3;
        bus.wdata     = 32'h55;
        bus.ram_wen   = 1'b1;
        bus.ram_addr  = 16'h0100;
        bus.ram_wdata = 32'hFFFF_0000;
        #1;
        check("hazard_pre_edge_rd1", bus.rdata1, 32'd4);
        tick();
        bus.we      = 1'b0;
        bus.ram_wen = 1'b0;
        #1;
        check("hazard_mem", bus.ram_rdata, 32'd4);
        check("hazard_reg", bus.rdata1, 32'h55);

        // Both cross paths on one edge
        bus.choice   = 2'b10;
        bus.raddr1   = 5'd3;
        bus.ram_addr = 16'h0100;
        bus.we       = 1'b1;
        bus.waddr    = 5'd10;
        bus.wdata    = 32'hCAFE_0000;
        bus.ram_wen  = 1'b1;
        tick();
        bus.we      = 1'b0;
        bus.ram_wen = 1'b0;
        bus.raddr2  = 5'd10;
        #1;
        check("swap_reg", bus.rdata2, 32'd4);
        check("swap_mem", bus.ram_rdata, 32'h55);

        // Seed a RAM window so random cross transfers stay inside known words
        bus.choice  = 2'b11;
        bus.ram_wen = 1'b1;
        for (int a = 16'h0200; a < 16'h0210; a++) begin
            bus.ram_addr  = 16'(a);
            bus.ram_wdata = $urandom;
            tick();
        end

        // Randomized mixed traffic
        for (int n = 0; n < 300; n++) begin
            bus.choice    = 2'($urandom_range(0, 3));
            bus.ram_wen   = 1'($urandom_range(0, 1));
            bus.we        = 1'($urandom_range(0, 1));
            bus.ram_addr  = 16'($urandom_range(16'h0200, 16'h020F));
            bus.ram_wdata = $urandom;
            bus.waddr     = 5'($urandom_range(0, 31));
            bus.wdata     = $urandom;
            bus.raddr1    = 5'($urandom_range(0, 31));
            bus.raddr2    = 5'($urandom_range(0, 31));
            #1;
            check("rand_pre_rd1", bus.rdata1, ref_reg[bus.raddr1]);
            tick();
            check("rand_rd1", bus.rdata1, ref_reg[bus.raddr1]);
            check("rand_rd2", bus.rdata2, ref_reg[bus.raddr2]);
            check("rand_ram", bus.ram_rdata, ref_ram_read(int'(bus.ram_addr)));
        end

        // Reset mid-write: both writes dropped, registers cleared, RAM kept
        idle_inputs();
        bus.we    = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.raddr1 = 5'd7;
        #1;
        check("preload_r7", bus.rdata1, 32'hDEAD_BEEF);
        rst           = 1'b1;
        bus.wdata     = 32'd1;
        bus.ram_wen   = 1'b1;
        bus.ram_addr  = 16'd9;
        bus.ram_wdata = 32'hAA;
        tick();
        rst = 1'b0;
        check("reset_r7", bus.rdata1, 32'd0);
        check("reset_mem9", bus.ram_rdata, 32'd16);
        bus.we      = 1'b0;
        bus.ram_wen = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            bus.ram_addr = 16'(k);
            bus.raddr2   = 5'(k % 32);
            #1;
            check("reset_ram_kept", bus.ram_rdata, ref_ram_read(k));
            check("reset_regs_zero", bus.rdata2, 32'd0);
        end

        // Writes resume right after reset deasserts
        bus.ram_wen   = 1'b1;
        bus.ram_addr  = 16'd9;
        bus.ram_wdata = 32'hAA;
        bus.we        = 1'b1;
        bus.waddr     = 5'd7;
        bus.wdata     = 32'd1;
        tick();
        bus.we      = 1'b0;
        bus.ram_wen = 1'b0;
        bus.raddr1  = 5'd7;
        #1;
        check("resume_mem9", bus.ram_rdata, 32'hAA);
        check("resume_r7", bus.rdata1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $fatal(1, "FAIL timeout: simulation did not finish, observed running expected done");
    end
endmodule
